// File: rtl/hazard_unit.sv
// Stall/freeze controller for hazards that forwarding cannot cover: load-use in EX,
// ID-resolved branches on in-flight results, and data-memory wait states.
module hazard_unit #(
  parameter int CNT_W      = 16,
  parameter int FREEZE_MAX = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_rs_i,
  input  logic [4:0]       IF_ID_rt_i,
  input  logic             ID_Branch_i,
  input  logic             ID_EX_MemRead_i,
  input  logic             ID_EX_RegWrite_i,
  input  logic [4:0]       ID_EX_rd_i,
  input  logic             EX_M_MemRead_i,
  input  logic [4:0]       EX_M_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             ID_EX_bubble_o,
  output logic             IF_ID_flush_o,
  output logic             pipe_freeze_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic             timeout_o,
  output logic             dbg_state_o
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FREEZE = 1'b1
  } state_t;

  localparam int               FRZ_W     = 16;
  localparam logic [FRZ_W-1:0] FRZ_LIMIT = FRZ_W'(FREEZE_MAX);
  localparam logic [FRZ_W-1:0] FRZ_SAT   = '1;
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_t             state_q, state_d;
  logic [FRZ_W-1:0]   frz_cnt_q, frz_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               timeout_q, timeout_d;

  logic               load_use, br_ex, br_mem, hazard;

  // Register 0 is hardwired, so a write to it can never feed a consumer.
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (r != 5'd0) && ((r == rs) || (r == rt));
  endfunction

  always_comb begin
    load_use = ID_EX_MemRead_i & reg_match(ID_EX_rd_i, IF_ID_rs_i, IF_ID_rt_i);
    br_ex    = ID_Branch_i & ID_EX_RegWrite_i & reg_match(ID_EX_rd_i, IF_ID_rs_i, IF_ID_rt_i);
    br_mem   = ID_Branch_i & EX_M_MemRead_i & reg_match(EX_M_rd_i, IF_ID_rs_i, IF_ID_rt_i);
    hazard   = load_use | br_ex | br_mem;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      frz_cnt_q   <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frz_cnt_q   <= frz_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frz_cnt_d = frz_cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_busy_i) begin
          state_d   = ST_FREEZE;
          frz_cnt_d = FRZ_W'(1);
        end
      end
      ST_FREEZE: begin
        if (!mem_busy_i) begin
          state_d   = ST_RUN;
          frz_cnt_d = '0;
        end else begin
          if (frz_cnt_q != FRZ_SAT) frz_cnt_d = frz_cnt_q + FRZ_W'(1);
          // Still busy after FREEZE_MAX completed freeze cycles: the limit is exceeded.
          if (frz_cnt_q >= FRZ_LIMIT) timeout_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_RUN;
        frz_cnt_d = '0;
      end
    endcase
  end

  // Freeze outranks hazard so no bubble is lost while the later stages are held.
  always_comb begin
    PC_write_o     = 1'b0;
    IF_ID_write_o  = 1'b0;
    ID_EX_bubble_o = 1'b0;
    IF_ID_flush_o  = 1'b0;
    pipe_freeze_o  = 1'b0;
    if (rst_i) begin
      PC_write_o = 1'b0;
    end else if (mem_busy_i) begin
      pipe_freeze_o = 1'b1;
    end else if (hazard) begin
      ID_EX_bubble_o = 1'b1;
    end else begin
      PC_write_o    = 1'b1;
      IF_ID_write_o = 1'b1;
      IF_ID_flush_o = branch_taken_i;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_write_o && (stall_cnt_q != CNT_SAT)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign stall_count_o = stall_cnt_q;
  assign timeout_o     = timeout_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: stalls, register-0 masking, branch-on-load,
// freeze priority, freeze watchdog, async reset and counter saturation.
module tb_hazard_unit;

  localparam int CNT_W      = 4;
  localparam int FREEZE_MAX = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       if_id_rs, if_id_rt, id_ex_rd, ex_m_rd;
  logic             id_branch, id_ex_memread, id_ex_regwrite, ex_m_memread;
  logic             branch_taken, mem_busy;
  logic             pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze;
  logic [CNT_W-1:0] stall_count;
  logic             timeout;
  logic             dbg_state;
  logic [4:0]       outs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(CNT_W), .FREEZE_MAX(FREEZE_MAX)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .IF_ID_rs_i      (if_id_rs),
    .IF_ID_rt_i      (if_id_rt),
    .ID_Branch_i     (id_branch),
    .ID_EX_MemRead_i (id_ex_memread),
    .ID_EX_RegWrite_i(id_ex_regwrite),
    .ID_EX_rd_i      (id_ex_rd),
    .EX_M_MemRead_i  (ex_m_memread),
    .EX_M_rd_i       (ex_m_rd),
    .branch_taken_i  (branch_taken),
    .mem_busy_i      (mem_busy),
    .PC_write_o      (pc_write),
    .IF_ID_write_o   (if_id_write),
    .ID_EX_bubble_o  (id_ex_bubble),
    .IF_ID_flush_o   (if_id_flush),
    .pipe_freeze_o   (pipe_freeze),
    .stall_count_o   (stall_count),
    .timeout_o       (timeout),
    .dbg_state_o     (dbg_state)
  );

  // {PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_freeze}
  assign outs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic br, input logic ex_mr, input logic ex_rw, input logic [4:0] ex_rd,
                       input logic m_mr, input logic [4:0] m_rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic taken, input logic busy);
    id_branch      = br;
    id_ex_memread  = ex_mr;
    id_ex_regwrite = ex_rw;
    id_ex_rd       = ex_rd;
    ex_m_memread   = m_mr;
    ex_m_rd        = m_rd;
    if_id_rs       = rs;
    if_id_rt       = rt;
    branch_taken   = taken;
    mem_busy       = busy;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_outs", 32'(outs), 32'b00000);
    chk("rst_cnt", 32'(stall_count), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_state", 32'(dbg_state), 0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("idle_outs", 32'(outs), 32'b11000);
    cyc();
    chk("idle_cnt", 32'(stall_count), 0);

    // load-use: one stall cycle, then the bubbled load no longer matches
    drive(0, 1, 1, 5, 0, 0, 5, 0, 0, 0);
    chk("lu_outs", 32'(outs), 32'b00100);
    cyc();
    chk("lu_cnt", 32'(stall_count), 1);
    drive(0, 0, 1, 5, 0, 0, 5, 0, 0, 0);
    chk("lu_release_outs", 32'(outs), 32'b11000);
    cyc();
    chk("lu_release_cnt", 32'(stall_count), 1);

    // hazard with taken branch: stall wins, no flush
    drive(0, 1, 1, 5, 0, 0, 5, 0, 1, 0);
    chk("lu_taken_outs", 32'(outs), 32'b00100);
    cyc();
    chk("lu_taken_cnt", 32'(stall_count), 2);
    drive(0, 0, 0, 0, 0, 0, 5, 0, 1, 0);
    chk("taken_flush_outs", 32'(outs), 32'b11010);
    cyc();

    // register 0 never creates a hazard
    drive(0, 1, 1, 0, 0, 0, 3, 0, 0, 0);
    chk("reg0_outs", 32'(outs), 32'b11000);
    cyc();
    chk("reg0_cnt", 32'(stall_count), 2);

    // branch on ALU result in EX
    drive(1, 0, 1, 9, 0, 0, 9, 2, 0, 0);
    chk("br_ex_outs", 32'(outs), 32'b00100);
    cyc();
    chk("br_ex_cnt", 32'(stall_count), 3);

    // load in MEM only matters for a branch
    drive(0, 0, 0, 0, 1, 7, 7, 0, 0, 0);
    chk("mem_nobranch_outs", 32'(outs), 32'b11000);
    cyc();

    // branch on load result: two stall cycles then the flush
    drive(1, 1, 1, 8, 0, 0, 1, 8, 1, 0);
    chk("brld_c1_outs", 32'(outs), 32'b00100);
    cyc();
    drive(1, 0, 0, 0, 1, 8, 1, 8, 1, 0);
    chk("brld_c2_outs", 32'(outs), 32'b00100);
    cyc();
    chk("brld_cnt", 32'(stall_count), 5);
    drive(1, 0, 0, 0, 0, 8, 1, 8, 1, 0);
    chk("brld_c3_outs", 32'(outs), 32'b11010);
    cyc();
    chk("brld_c3_cnt", 32'(stall_count), 5);

    // freeze during a load-use match: no bubble until the freeze ends
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 5, 0, 0, 5, 0, 0, 1);
      chk("frz_hz_outs", 32'(outs), 32'b00001);
      chk("frz_hz_state", 32'(dbg_state), (i == 0) ? 0 : 1);
      cyc();
    end
    drive(0, 1, 1, 5, 0, 0, 5, 0, 0, 0);
    chk("frz_hz_bubble_outs", 32'(outs), 32'b00100);
    chk("frz_hz_timeout", 32'(timeout), 0);
    cyc();
    chk("frz_hz_cnt", 32'(stall_count), 9);
    chk("frz_hz_state_run", 32'(dbg_state), 0);

    // asynchronous reset pulse between edges
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(stall_count), 0);
    chk("arst_outs", 32'(outs), 32'b00000);
    rst = 1'b0;
    #1;
    chk("arst_release_outs", 32'(outs), 32'b11000);

    // watchdog: busy for 6 cycles, limit 4
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("wd_outs", 32'(outs), 32'b00001);
      chk("wd_timeout", 32'(timeout), (i == 5) ? 1 : 0);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wd_after_timeout", 32'(timeout), 1);
    chk("wd_after_outs", 32'(outs), 32'b11000);
    chk("wd_after_cnt", 32'(stall_count), 6);
    cyc();
    chk("wd_sticky", 32'(timeout), 1);

    // reset with a hazard pending, then outputs follow current inputs
    drive(0, 1, 1, 5, 0, 0, 5, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("arst2_outs", 32'(outs), 32'b00000);
    chk("arst2_timeout", 32'(timeout), 0);
    chk("arst2_cnt", 32'(stall_count), 0);
    rst = 1'b0;
    #1;
    chk("arst2_release_outs", 32'(outs), 32'b00100);

    // saturation of the 4-bit stall counter
    for (int i = 1; i <= 20; i++) begin
      cyc();
      chk("sat_cnt", 32'(stall_count), (i < 15) ? i : 15);
    end
    chk("sat_outs", 32'(outs), 32'b00100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
